// File: rtl/eth_phy_10g_pkg.sv
// ----------------------------------------------------------------------------
// eth_phy_10g_pkg
// Shared definitions for the 10G/25G/40G PHY receive frame-sync slice.
//   SYNC_DATA / SYNC_CTRL : the two legal 64b/66b sync header patterns
//   lane_state_t          : per-lane block-lock state
//   sync_hdr_ok()         : true when a 2-bit header is one of the legal patterns
// ----------------------------------------------------------------------------
package eth_phy_10g_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    // HUNT is encoded as zero so that a cleared state register means "hunting"
    typedef enum logic [1:0] {
        LANE_HUNT      = 2'd0,
        LANE_LOCK      = 2'd1,
        LANE_SLIP_HIGH = 2'd2,
        LANE_SLIP_LOW  = 2'd3
    } lane_state_t;

    // 2'b00 and 2'b11 can never appear on an aligned 66-bit block
    function automatic logic sync_hdr_ok(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/eth_phy_10g_rx_frame_sync_mc_if.sv
// ----------------------------------------------------------------------------
// eth_phy_10g_rx_frame_sync_mc_if
// Bundles the gearbox-facing and status signals of the multi-lane frame sync.
//   serdes_rx_hdr        : per-lane sync header, lane n at [2n+1:2n]
//   serdes_rx_hdr_valid  : per-lane header qualifier
//   serdes_rx_bitslip    : per-lane slip request back to the gearbox
//   rx_block_lock        : per-lane block lock
//   rx_block_lock_all    : AND of all lane locks
//   rx_slip_wrap         : per-lane pulse after SLIP_LIMIT slips without lock
//   rx_lock_loss_count   : per-lane 8-bit lock-loss counters (stats build only)
//   stats_clear          : synchronous clear of the counters (stats build only)
// Optional feature macro: ETH_PHY_RX_FRAME_SYNC_STATS_EN
// Modports: master = gearbox/system side, slave = frame-sync block.
// ----------------------------------------------------------------------------
interface eth_phy_10g_rx_frame_sync_mc_if #(
    parameter int LANES     = 1,
    parameter int HDR_WIDTH = 2
);
    import eth_phy_10g_pkg::*;

    logic [LANES*HDR_WIDTH-1:0] serdes_rx_hdr;
    logic [LANES-1:0]           serdes_rx_hdr_valid;
    logic [LANES-1:0]           serdes_rx_bitslip;
    logic [LANES-1:0]           rx_block_lock;
    logic                       rx_block_lock_all;
    logic [LANES-1:0]           rx_slip_wrap;

`ifdef ETH_PHY_RX_FRAME_SYNC_STATS_EN
    logic [LANES*8-1:0]         rx_lock_loss_count;
    logic                       stats_clear;

    modport master (
        output serdes_rx_hdr, serdes_rx_hdr_valid, stats_clear,
        input  serdes_rx_bitslip, rx_block_lock, rx_block_lock_all,
               rx_slip_wrap, rx_lock_loss_count
    );

    modport slave (
        input  serdes_rx_hdr, serdes_rx_hdr_valid, stats_clear,
        output serdes_rx_bitslip, rx_block_lock, rx_block_lock_all,
               rx_slip_wrap, rx_lock_loss_count
    );
`else
    modport master (
        output serdes_rx_hdr, serdes_rx_hdr_valid,
        input  serdes_rx_bitslip, rx_block_lock, rx_block_lock_all, rx_slip_wrap
    );

    modport slave (
        input  serdes_rx_hdr, serdes_rx_hdr_valid,
        output serdes_rx_bitslip, rx_block_lock, rx_block_lock_all, rx_slip_wrap
    );
`endif

endinterface

// File: rtl/eth_phy_10g_rx_frame_sync_lane.sv
// ----------------------------------------------------------------------------
// eth_phy_10g_rx_frame_sync_lane
// Single-lane 64b/66b block-lock engine: checks sync headers, requests
// bitslips until SH_WINDOW consecutive valid headers are seen, then monitors
// the lock and drops it after SH_INVALID_MAX bad headers in one window.
// Ports:
//   clk, rst           : receive clock, asynchronous active-high reset
//   hdr, hdr_valid     : sync header and its gearbox qualifier
//   bitslip            : registered slip request
//   block_lock         : registered lock indication
//   slip_wrap          : one-cycle pulse when SLIP_LIMIT slips pass without lock
//   stats_clear        : clears lock_loss_count (stats build only)
//   lock_loss_count    : saturating count of lock losses (stats build only)
// Optional feature macro: ETH_PHY_RX_FRAME_SYNC_STATS_EN
// ----------------------------------------------------------------------------
module eth_phy_10g_rx_frame_sync_lane
    import eth_phy_10g_pkg::*;
#(
    parameter int SH_WINDOW           = 64,
    parameter int SH_INVALID_MAX      = 16,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 8,
    parameter int SLIP_LIMIT          = 66
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] hdr,
    input  logic       hdr_valid,
    output logic       bitslip,
    output logic       block_lock,
    output logic       slip_wrap
`ifdef ETH_PHY_RX_FRAME_SYNC_STATS_EN
    ,
    input  logic       stats_clear,
    output logic [7:0] lock_loss_count
`endif
);

    localparam int SH_W   = $clog2(SH_WINDOW);
    localparam int IC_W   = $clog2(SH_INVALID_MAX + 1);
    localparam int SC_W   = $clog2(SLIP_LIMIT + 1);
    localparam int HO_MAX = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
                            BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
    localparam int HO_W   = (HO_MAX > 1) ? $clog2(HO_MAX) : 1;

    localparam logic [SH_W-1:0] SH_LAST   = SH_W'(SH_WINDOW - 1);
    localparam logic [IC_W-1:0] IC_LIMIT  = IC_W'(SH_INVALID_MAX);
    localparam logic [SC_W-1:0] SC_LIMIT  = SC_W'(SLIP_LIMIT);
    localparam logic [HO_W-1:0] HIGH_LOAD = HO_W'(BITSLIP_HIGH_CYCLES - 1);
    localparam logic [HO_W-1:0] LOW_LOAD  =
        HO_W'((BITSLIP_LOW_CYCLES > 0) ? BITSLIP_LOW_CYCLES - 1 : 0);
    // A lock loss counts as the first slip of a new hunt; with a limit of one
    // that single slip already wraps.
    localparam logic            DROP_WRAPS = (SLIP_LIMIT <= 1);

    lane_state_t     state;
    logic [SH_W-1:0] sh_count;
    logic [IC_W-1:0] invalid_count;
    logic [HO_W-1:0] holdoff;
    logic [SC_W-1:0] slip_count;

    logic            hdr_ok;
    logic [IC_W-1:0] invalid_next;
    logic [SC_W-1:0] slip_next;
    logic            lock_drop;

    assign hdr_ok       = sync_hdr_ok(hdr);
    assign invalid_next = invalid_count + IC_W'(1);
    assign slip_next    = slip_count + SC_W'(1);
    // Lock loss takes priority over the end-of-window clear
    assign lock_drop    = (state == LANE_LOCK) && hdr_valid && !hdr_ok &&
                          (invalid_next == IC_LIMIT);

    // Lane state machine: headers only matter in HUNT/LOCK while qualified;
    // the slip phases time out on every clock regardless of hdr_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= LANE_HUNT;
            sh_count      <= '0;
            invalid_count <= '0;
            holdoff       <= '0;
            slip_count    <= '0;
            bitslip       <= 1'b0;
            block_lock    <= 1'b0;
            slip_wrap     <= 1'b0;
        end else begin
            slip_wrap <= 1'b0;
            case (state)
                LANE_HUNT: begin
                    if (hdr_valid) begin
                        if (!hdr_ok) begin
                            sh_count <= '0;
                            state    <= LANE_SLIP_HIGH;
                            bitslip  <= 1'b1;
                            holdoff  <= HIGH_LOAD;
                            if (slip_next == SC_LIMIT) begin
                                slip_wrap  <= 1'b1;
                                slip_count <= '0;
                            end else begin
                                slip_count <= slip_next;
                            end
                        end else if (sh_count == SH_LAST) begin
                            state         <= LANE_LOCK;
                            block_lock    <= 1'b1;
                            sh_count      <= '0;
                            invalid_count <= '0;
                            slip_count    <= '0;
                        end else begin
                            sh_count <= sh_count + SH_W'(1);
                        end
                    end
                end
                LANE_LOCK: begin
                    if (hdr_valid) begin
                        if (lock_drop) begin
                            state         <= LANE_SLIP_HIGH;
                            block_lock    <= 1'b0;
                            bitslip       <= 1'b1;
                            holdoff       <= HIGH_LOAD;
                            sh_count      <= '0;
                            invalid_count <= '0;
                            slip_count    <= DROP_WRAPS ? '0 : SC_W'(1);
                            slip_wrap     <= DROP_WRAPS;
                        end else if (sh_count == SH_LAST) begin
                            sh_count      <= '0;
                            invalid_count <= '0;
                        end else begin
                            sh_count <= sh_count + SH_W'(1);
                            if (!hdr_ok) begin
                                invalid_count <= invalid_next;
                            end
                        end
                    end
                end
                LANE_SLIP_HIGH: begin
                    if (holdoff == '0) begin
                        bitslip <= 1'b0;
                        if (BITSLIP_LOW_CYCLES == 0) begin
                            state <= LANE_HUNT;
                        end else begin
                            state   <= LANE_SLIP_LOW;
                            holdoff <= LOW_LOAD;
                        end
                    end else begin
                        holdoff <= holdoff - HO_W'(1);
                    end
                end
                LANE_SLIP_LOW: begin
                    if (holdoff == '0) begin
                        state <= LANE_HUNT;
                    end else begin
                        holdoff <= holdoff - HO_W'(1);
                    end
                end
                default: begin
                    state <= LANE_HUNT;
                end
            endcase
        end
    end

`ifdef ETH_PHY_RX_FRAME_SYNC_STATS_EN
    // Saturating lock-loss counter; a clear in the same cycle as a loss wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_loss_count <= 8'd0;
        end else if (stats_clear) begin
            lock_loss_count <= 8'd0;
        end else if (lock_drop && (lock_loss_count != 8'hFF)) begin
            lock_loss_count <= lock_loss_count + 8'd1;
        end
    end
`endif

endmodule

// File: rtl/eth_phy_10g_rx_frame_sync_mc.sv
// ----------------------------------------------------------------------------
// eth_phy_10g_rx_frame_sync_mc
// Multi-lane 64b/66b block-lock engine between the SERDES gearbox and the
// descrambler. One independent lane engine per lane plus the all-lanes lock.
// Ports:
//   clk  : PHY receive clock
//   rst  : asynchronous active-high reset
//   bus  : eth_phy_10g_rx_frame_sync_mc_if.slave (headers in, slip/lock/
//          wrap/stats out, stats_clear in)
// Optional feature macro: ETH_PHY_RX_FRAME_SYNC_STATS_EN (lock-loss counters)
// ----------------------------------------------------------------------------
module eth_phy_10g_rx_frame_sync_mc
    import eth_phy_10g_pkg::*;
#(
    parameter int LANES               = 1,
    parameter int HDR_WIDTH           = 2,
    parameter int SH_WINDOW           = 64,
    parameter int SH_INVALID_MAX      = 16,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 8,
    parameter int SLIP_LIMIT          = 66
) (
    input  logic                           clk,
    input  logic                           rst,
    eth_phy_10g_rx_frame_sync_mc_if.slave  bus
);

    // Catch unsupported configurations at elaboration rather than in the lab
    if (HDR_WIDTH != 2) begin : g_bad_hdr_width
        $fatal(1, "eth_phy_10g_rx_frame_sync_mc: HDR_WIDTH must be 2");
    end
    if (LANES < 1 || LANES > 4) begin : g_bad_lanes
        $fatal(1, "eth_phy_10g_rx_frame_sync_mc: LANES must be 1..4");
    end
    if ((SH_WINDOW & (SH_WINDOW - 1)) != 0 || SH_WINDOW < 16 || SH_WINDOW > 1024) begin : g_bad_window
        $fatal(1, "eth_phy_10g_rx_frame_sync_mc: SH_WINDOW must be a power of two in 16..1024");
    end
    if (SH_INVALID_MAX < 2 || SH_INVALID_MAX > SH_WINDOW / 2) begin : g_bad_invalid_max
        $fatal(1, "eth_phy_10g_rx_frame_sync_mc: SH_INVALID_MAX out of range");
    end
    if (BITSLIP_HIGH_CYCLES < 1 || BITSLIP_LOW_CYCLES < 0) begin : g_bad_slip_cycles
        $fatal(1, "eth_phy_10g_rx_frame_sync_mc: bitslip cycle counts out of range");
    end

    logic [LANES-1:0]   lane_bitslip;
    logic [LANES-1:0]   lane_lock;
    logic [LANES-1:0]   lane_wrap;
`ifdef ETH_PHY_RX_FRAME_SYNC_STATS_EN
    logic [LANES*8-1:0] lane_stats;
`endif

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        eth_phy_10g_rx_frame_sync_lane #(
            .SH_WINDOW           (SH_WINDOW),
            .SH_INVALID_MAX      (SH_INVALID_MAX),
            .BITSLIP_HIGH_CYCLES (BITSLIP_HIGH_CYCLES),
            .BITSLIP_LOW_CYCLES  (BITSLIP_LOW_CYCLES),
            .SLIP_LIMIT          (SLIP_LIMIT)
        ) u_lane (
            .clk             (clk),
            .rst             (rst),
            .hdr             (bus.serdes_rx_hdr[2*n +: 2]),
            .hdr_valid       (bus.serdes_rx_hdr_valid[n]),
            .bitslip         (lane_bitslip[n]),
            .block_lock      (lane_lock[n]),
            .slip_wrap       (lane_wrap[n])
`ifdef ETH_PHY_RX_FRAME_SYNC_STATS_EN
            ,
            .stats_clear     (bus.stats_clear),
            .lock_loss_count (lane_stats[8*n +: 8])
`endif
        );
    end

    assign bus.serdes_rx_bitslip = lane_bitslip;
    assign bus.rx_block_lock     = lane_lock;
    assign bus.rx_slip_wrap      = lane_wrap;
    // Only combinational output: AND of registered lock bits, so it is glitch-safe
    assign bus.rx_block_lock_all = &lane_lock;
`ifdef ETH_PHY_RX_FRAME_SYNC_STATS_EN
    assign bus.rx_lock_loss_count = lane_stats;
`endif

endmodule

// File: tb/tb_eth_phy_10g_rx_frame_sync_mc.sv
// ----------------------------------------------------------------------------
// tb_eth_phy_10g_rx_frame_sync_mc
// Self-checking bench for the two-lane frame sync. A lane model tracks
// "slip cycles still to burn", the current run of good headers and the
// window/invalid tallies, and predicts every output each cycle.
// Optional feature macro: ETH_PHY_RX_FRAME_SYNC_STATS_EN
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_eth_phy_10g_rx_frame_sync_mc;

    localparam int LANES = 2;
    localparam int W     = 64;
    localparam int IMAX  = 16;
    localparam int HC    = 1;
    localparam int LC    = 8;
    localparam int LIMIT = 66;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    eth_phy_10g_rx_frame_sync_mc_if #(.LANES(LANES), .HDR_WIDTH(2)) bus();

    eth_phy_10g_rx_frame_sync_mc #(
        .LANES               (LANES),
        .HDR_WIDTH           (2),
        .SH_WINDOW           (W),
        .SH_INVALID_MAX      (IMAX),
        .BITSLIP_HIGH_CYCLES (HC),
        .BITSLIP_LOW_CYCLES  (LC),
        .SLIP_LIMIT          (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passCount  = 0;
    int checkCount = 0;

    // Lane model state
    int mBusy  [LANES];
    int mRun   [LANES];
    int mWin   [LANES];
    int mBad   [LANES];
    int mSlips [LANES];
    int mLoss  [LANES];
    bit mLock  [LANES];
    bit mWrap  [LANES];
    int wrapSeen [LANES];

    task automatic checkValue(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int n = 0; n < LANES; n++) begin
            mBusy[n] = 0; mRun[n] = 0; mWin[n] = 0; mBad[n] = 0;
            mSlips[n] = 0; mLoss[n] = 0; mLock[n] = 0; mWrap[n] = 0;
        end
    endtask

    task automatic startSlip(input int n, input int count);
        mBusy[n] = HC + LC;
        if (count == LIMIT) begin
            mWrap[n]  = 1;
            mSlips[n] = 0;
        end else begin
            mSlips[n] = count;
        end
    endtask

    // Predict the outputs after the coming rising edge from the current inputs
    task automatic modelStep();
        logic [1:0] h;
        bit good;
        bit lost;
        bit clr;
        clr = 0;
`ifdef ETH_PHY_RX_FRAME_SYNC_STATS_EN
        clr = bus.stats_clear;
`endif
        for (int n = 0; n < LANES; n++) begin
            h    = bus.serdes_rx_hdr[2*n +: 2];
            good = (h == 2'b01) || (h == 2'b10);
            lost = 0;
            mWrap[n] = 0;
            if (mBusy[n] > 0) begin
                mBusy[n]--;
            end else if (bus.serdes_rx_hdr_valid[n]) begin
                if (!mLock[n]) begin
                    if (good) begin
                        mRun[n]++;
                        if (mRun[n] == W) begin
                            mLock[n] = 1; mRun[n] = 0; mWin[n] = 0; mBad[n] = 0; mSlips[n] = 0;
                        end
                    end else begin
                        mRun[n] = 0;
                        startSlip(n, mSlips[n] + 1);
                    end
                end else begin
                    mWin[n]++;
                    if (!good) mBad[n]++;
                    if (mBad[n] == IMAX) begin
                        mLock[n] = 0; mWin[n] = 0; mBad[n] = 0; lost = 1;
                        startSlip(n, 1);
                    end else if (mWin[n] == W) begin
                        mWin[n] = 0; mBad[n] = 0;
                    end
                end
            end
            if (clr) mLoss[n] = 0;
            else if (lost && mLoss[n] < 255) mLoss[n]++;
        end
    endtask

    task automatic checkOutput();
        logic [LANES-1:0] expLock;
        for (int n = 0; n < LANES; n++) begin
            checkValue($sformatf("lane%0d_bitslip", n), int'(bus.serdes_rx_bitslip[n]), (mBusy[n] > LC) ? 1 : 0);
            checkValue($sformatf("lane%0d_lock", n), int'(bus.rx_block_lock[n]), int'(mLock[n]));
            checkValue($sformatf("lane%0d_wrap", n), int'(bus.rx_slip_wrap[n]), int'(mWrap[n]));
`ifdef ETH_PHY_RX_FRAME_SYNC_STATS_EN
            checkValue($sformatf("lane%0d_loss_count", n), int'(bus.rx_lock_loss_count[8*n +: 8]), mLoss[n]);
`endif
            expLock[n] = mLock[n];
            if (bus.rx_slip_wrap[n]) wrapSeen[n]++;
        end
        checkValue("lock_all", int'(bus.rx_block_lock_all), int'(&expLock));
    endtask

    // Drive one cycle of inputs (called at a falling edge), then check after the next edge
    task automatic applyStimulus(input logic [2*LANES-1:0] hdr, input logic [LANES-1:0] valid, input logic clr);
        bus.serdes_rx_hdr       = hdr;
        bus.serdes_rx_hdr_valid = valid;
`ifdef ETH_PHY_RX_FRAME_SYNC_STATS_EN
        bus.stats_clear = clr;
`else
        if (clr) begin end
`endif
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic doReset();
        rst = 1'b1;
        bus.serdes_rx_hdr       = '0;
        bus.serdes_rx_hdr_valid = '0;
`ifdef ETH_PHY_RX_FRAME_SYNC_STATS_EN
        bus.stats_clear = 1'b0;
`endif
        modelReset();
        @(negedge clk);
        checkOutput();
        rst = 1'b0;
    endtask

    // One lock/loss round on lane 0 while lane 1 stays healthy
    task automatic lockAndLose(input logic lastClr);
        repeat (80) applyStimulus(4'b1010, 2'b11, 1'b0);
        repeat (IMAX - 1) applyStimulus(4'b1000, 2'b11, 1'b0);
        applyStimulus(4'b1000, 2'b11, lastClr);
    endtask

    initial begin
        int pct [LANES];
        logic [2*LANES-1:0] h;
        logic [LANES-1:0] v;

        // Reset state
        doReset();
        checkValue("reset_bitslip", int'(bus.serdes_rx_bitslip), 0);
        checkValue("reset_lock", int'(bus.rx_block_lock), 0);

        // Both lanes clean: lock one clock after the 64th header
        $display("[TB] clean lock");
        repeat (W - 1) applyStimulus(4'b1010, 2'b11, 1'b0);
        checkValue("t1_lock_before", int'(bus.rx_block_lock), 0);
        applyStimulus(4'b1010, 2'b11, 1'b0);
        checkValue("t1_lock", int'(bus.rx_block_lock), 3);
        checkValue("t1_lock_all", int'(bus.rx_block_lock_all), 1);

        // Invalid threshold: 15 per window survives, the 16th drops lock
        $display("[TB] invalid threshold");
        repeat (49) applyStimulus(4'b1001, 2'b11, 1'b0);
        repeat (15) applyStimulus(4'b1011, 2'b11, 1'b0);
        checkValue("t3_lock_after_15", int'(bus.rx_block_lock), 3);
        repeat (15) applyStimulus(4'b1000, 2'b11, 1'b0);
        checkValue("t3_lock_next_window", int'(bus.rx_block_lock), 3);
        applyStimulus(4'b1001, 2'b11, 1'b0);
        applyStimulus(4'b1000, 2'b11, 1'b0);
        checkValue("t3_lock_dropped", int'(bus.rx_block_lock), 2);
        checkValue("t3_bitslip", int'(bus.serdes_rx_bitslip), 1);
        checkValue("t3_lock_all", int'(bus.rx_block_lock_all), 0);
`ifdef ETH_PHY_RX_FRAME_SYNC_STATS_EN
        checkValue("t3_loss_count", int'(bus.rx_lock_loss_count[7:0]), 1);
`endif

        // Permanent bad header on lane 0: exactly one wrap in 700 cycles
        $display("[TB] slip wrap");
        doReset();
        for (int n = 0; n < LANES; n++) wrapSeen[n] = 0;
        repeat (700) applyStimulus(4'b0100, 2'b11, 1'b0);
        checkValue("t2_wraps_lane0", wrapSeen[0], 1);
        checkValue("t2_wraps_lane1", wrapSeen[1], 0);

        // Gearbox pauses: garbage while unqualified is ignored
        $display("[TB] header qualification");
        doReset();
        for (int i = 0; i < 2 * W - 1; i++) begin
            if (i % 2 == 0) applyStimulus(4'b0110, 2'b11, 1'b0);
            else            applyStimulus(4'b1111, 2'b00, 1'b0);
            if (i == 2 * W - 3) checkValue("t4_lock_before", int'(bus.rx_block_lock), 0);
        end
        checkValue("t4_lock", int'(bus.rx_block_lock), 3);

        // Asynchronous reset while lane 0 is slipping with five losses on record
        $display("[TB] async reset");
        doReset();
        repeat (5) lockAndLose(1'b0);
        checkValue("t5_bitslip_before", int'(bus.serdes_rx_bitslip), 1);
        checkValue("t5_lock_before", int'(bus.rx_block_lock), 2);
`ifdef ETH_PHY_RX_FRAME_SYNC_STATS_EN
        checkValue("t5_loss_before", int'(bus.rx_lock_loss_count[7:0]), 5);
`endif
        #2 rst = 1'b1;
        #1;
        checkValue("t5_bitslip_async", int'(bus.serdes_rx_bitslip), 0);
        checkValue("t5_lock_async", int'(bus.rx_block_lock), 0);
        checkValue("t5_lock_all_async", int'(bus.rx_block_lock_all), 0);
`ifdef ETH_PHY_RX_FRAME_SYNC_STATS_EN
        checkValue("t5_loss_async", int'(bus.rx_lock_loss_count), 0);
`endif
        modelReset();
        @(negedge clk);
        checkOutput();
        rst = 1'b0;

`ifdef ETH_PHY_RX_FRAME_SYNC_STATS_EN
        // Saturation and clear-beats-increment
        $display("[TB] stats saturation");
        doReset();
        repeat (255) lockAndLose(1'b0);
        checkValue("t6_loss_255", int'(bus.rx_lock_loss_count[7:0]), 255);
        lockAndLose(1'b0);
        checkValue("t6_loss_saturated", int'(bus.rx_lock_loss_count[7:0]), 255);
        lockAndLose(1'b1);
        checkValue("t6_loss_clear_wins", int'(bus.rx_lock_loss_count[7:0]), 0);
`endif

        // Randomized traffic with per-lane error rates changing over time
        $display("[TB] random traffic");
        doReset();
        for (int blk = 0; blk < 16; blk++) begin
            for (int n = 0; n < LANES; n++) begin
                case ($urandom_range(0, 4))
                    0: pct[n] = 0;
                    1: pct[n] = 1;
                    2: pct[n] = 5;
                    3: pct[n] = 20;
                    default: pct[n] = 100;
                endcase
            end
            for (int c = 0; c < 250; c++) begin
                for (int n = 0; n < LANES; n++) begin
                    if ($urandom_range(0, 99) < pct[n]) h[2*n +: 2] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
                    else                                h[2*n +: 2] = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
                    v[n] = ($urandom_range(0, 9) != 0);
                end
                applyStimulus(h, v, ($urandom_range(0, 199) == 0));
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/eth_phy_10g_rx_frame_sync_mc.md
# eth_phy_10g_rx_frame_sync_mc

Multi-lane, parametrised 64b/66b block-lock engine for the 10G/25G/40G PHY receive path. Sits between the SERDES gearbox and the descrambler: checks each lane's 2-bit sync header and drives per-lane bitslip until the lane holds block lock. Generalises single-lane frame sync with:
- lane count, window and invalid-threshold parameters;
- gearbox header-valid qualification;
- slip-wrap detection;
- optional lock-loss statistics.

## Interface
- LANES, 1: number of independent lanes (1–4).
- HDR_WIDTH, 2: sync header width; any other value is a fatal elaboration error.
- SH_WINDOW, 64: headers per monitoring window; power of two, 16–1024.
- SH_INVALID_MAX, 16: invalid headers in one window that drop lock; 2–SH_WINDOW/2.
- BITSLIP_HIGH_CYCLES, 1: cycles bitslip is held high per slip (≥1).
- BITSLIP_LOW_CYCLES, 8: settle cycles after bitslip falls (≥0).
- SLIP_LIMIT, 66: slips without lock before a wrap pulse.

Ports:
- clk  in  1  PHY receive clock.
- rst  in  1  asynchronous, active-high reset.
- serdes_rx_hdr  in  LANES*HDR_WIDTH  per-lane sync header; lane n at [2n+1:2n].
- serdes_rx_hdr_valid  in  LANES  header qualifier (gearbox pause when low).
- serdes_rx_bitslip  out  LANES  per-lane slip request.
- rx_block_lock  out  LANES  per-lane block lock.
- rx_block_lock_all  out  1  AND of rx_block_lock.
- rx_slip_wrap  out  LANES  one-cycle pulse on SLIP_LIMIT slips without lock.
- rx_lock_loss_count  out  LANES*8  lane n at [8n+7:8n]; present only with stats enabled.
- stats_clear  in  1  synchronous clear of all stats counters; present only with stats enabled.

## Operation
Each lane runs independently. State per lane: SLIP_HIGH, SLIP_LOW, HUNT, LOCK. Counters: sh_count (log2 SH_WINDOW bits), invalid_count, holdoff, slip_count.

A header is valid iff it equals 2'b01 (ctrl) or 2'b10 (data). Headers are evaluated only in HUNT/LOCK and only while hdr_valid=1; otherwise all counters hold.

- **HUNT**
  - Valid header: sh_count+1.
  - Invalid header: sh_count=0, slip_count+1, enter SLIP_HIGH.
  - SH_WINDOW consecutive valid headers: enter LOCK, slip_count=0, counters cleared.
- **LOCK**
  - Every header: sh_count+1. Invalid header: invalid_count+1.
  - SH_INVALID_MAX-th invalid header in a window: lock drops, counters cleared, slip_count=1, enter SLIP_HIGH.
  - Otherwise, on the SH_WINDOW-th header: sh_count=0 and invalid_count=0.
  - If the SH_INVALID_MAX-th invalid header is also the SH_WINDOW-th header, lock loss wins.
- **SLIP_HIGH**
  - serdes_rx_bitslip=1 for BITSLIP_HIGH_CYCLES clocks, counted on every clock regardless of hdr_valid.
  - Then SLIP_LOW (or HUNT directly if BITSLIP_LOW_CYCLES=0).
- **SLIP_LOW**
  - serdes_rx_bitslip=0 for BITSLIP_LOW_CYCLES clocks, then HUNT; headers are ignored.
- **Slip wrap**
  - When slip_count reaches SLIP_LIMIT: rx_slip_wrap pulses for one cycle, coincident with entry to SLIP_HIGH, and slip_count resets to 0.
  - Hunting continues.

## Timing
- All outputs are registered except rx_block_lock_all, which is a combinational AND of registered lock bits.
- Header sampled at edge k → bitslip/lock/wrap change visible after edge k.
- Lock latency: from the first valid header in HUNT, rx_block_lock rises one clock after the SH_WINDOW-th valid qualified header is sampled.
- Reset asserted (any time, including mid-slip): all outputs 0 immediately, every lane returns to HUNT with counters 0, stats counters 0.
- Release is synchronised externally; the block runs from the first edge after deassertion.

## Configuration
- ETH_PHY_RX_FRAME_SYNC_STATS_EN defined:
  - rx_lock_loss_count and stats_clear exist.
  - Each 8-bit lane counter increments on LOCK→SLIP_HIGH and saturates at 255.
  - stats_clear and an increment in the same cycle: clear wins (result 0).
- Macro undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package eth_phy_10g_pkg holds SYNC_DATA=2'b10, SYNC_CTRL=2'b01 and the lane-state enum.
- Sub-module eth_phy_10g_rx_frame_sync_lane holds the single-lane FSM, counters and stats counter.
- The top level is a LANES-wide generate loop plus the lock AND.

## Test plan
1. LANES=2, both lanes present 2'b10 every cycle, hdr_valid=11 → rx_block_lock=11 and rx_block_lock_all=1 one clock after the 64th header; bitslip never asserts.
2. Lane 0 hdr=2'b00 from reset → bitslip high 1 cycle, low 8 cycles, repeat; after the 66th slip rx_slip_wrap[0] pulses exactly once and slip_count restarts.
3. Locked lane, 15 invalid headers in one window → lock held, counters clear at window end; 16 invalid headers in one window → lock drops next cycle, bitslip rises, rx_lock_loss_count=1.
4. hdr_valid toggles 1/0 with valid headers → lock takes 128 clocks (64 qualified headers); hdr=2'b11 while hdr_valid=0 → no effect.
5. rst asserted during SLIP_HIGH while locked-lane stats=5 → bitslip, lock and count go to 0 without a clock edge.
6. Stats counter at 255 plus another lock loss → stays 255; stats_clear coincident with a lock loss → 0.
